xbar_slave_mem: RTL and testbench
=================================

// Module: xbar_slave_mem
// PURPOSE
//  Memory-mapped slave endpoint on one slave port of the cross bar. It consumes the master->slave
//  request channel (req/addr/cmd/wdata), returns ack, and returns read data later via resp/rdata.
//  Holds a word-addressed RAM. Adds ack wait-states and fixed read latency so the cross bar arbiter
//  and its routing of responses can be exercised in simulation.
// PARAMETERS
//  DEPTH       256  number of 32-bit words; power of 2, >=2
//  ACK_WAIT    0    cycles req must be held before ack is given (0..15)
//  RD_LATENCY  2    cycles from read accept to the resp pulse (1..8)
// PORTS
//  clk                 in   1   clock, all logic on rising edge
//  rst                 in   1   synchronous reset, active-high
//  master_slave_req    in   1   request valid
//  master_slave_addr   in   32  byte address
//  master_slave_cmd    in   1   0 = read, 1 = write
//  master_slave_wdata  in   32  write data, valid with req
//  slave_master_ack    out  1   request accepted this cycle
//  slave_master_rdata  out  32  read data, valid while resp=1
//  slave_master_resp   out  1   one-cycle read-response strobe
// BEHAVIOUR
//  Reset (sync, active-high): ack=0, resp=0, rdata=0; wait counter=0; FSM=IDLE; read pipeline flushed.
//   RAM contents are NOT reset.
//  Accept: a transfer happens on a cycle where req&ack=1.
//   Master holds req/addr/cmd/wdata stable until ack. Slave samples all of them in the accept cycle.
//  Ack FSM (IDLE, WAIT):
//   - ack = req & (wcnt == ACK_WAIT); this is combinational from req and registered wcnt.
//   - IDLE: wcnt=0. If req and ACK_WAIT=0, ack now and stay in IDLE.
//     If req and ACK_WAIT>0, go to WAIT with wcnt=1.
//   - WAIT: if req dropped, go to IDLE with wcnt=0 (abandoned request, no access).
//     Else if wcnt<ACK_WAIT, increment wcnt.
//     When wcnt==ACK_WAIT, assert ack that cycle, then go to IDLE.
//   - With ACK_WAIT=0, back-to-back accepts at one per cycle are allowed.
//     With ACK_WAIT=N, at most one accept every N+1 cycles.
//  Addressing: index = addr[AW+1:2], where AW = clog2(DEPTH).
//   addr[1:0] is ignored. addr[31:AW+2] is ignored, so accesses alias with period 4*DEPTH bytes.
//  Write (cmd=1): mem[index] <= wdata at the accept edge. No resp is generated.
//  Read (cmd=0):
//   - mem[index] is read at the accept edge into stage 1 of a RD_LATENCY-deep valid/data shift pipeline.
//   - resp=1 and rdata=data exactly RD_LATENCY cycles after the accept edge, for one cycle.
//   - A read accepted the cycle after a write to the same index returns the new data.
//  Pipelining: up to RD_LATENCY reads are in flight. Responses return in accept order, one per cycle.
//   There is no back-pressure on resp; the receiver must take every strobe.
//  rdata between strobes: holds the last returned value (0 after reset).
//  Reset mid-operation: all in-flight reads are discarded and their resp is never issued.
//   An ack pending in WAIT is cancelled.
//  Reads and writes interleave freely. A write accepted while earlier reads are in flight does not
//   alter their already-captured data.
// TESTING
//  1. Defaults: write addr 0x0000_0010 data 0xDEAD_BEEF, then read 0x10.
//     -> ack in the same cycle as each req; resp=1 with rdata=0xDEAD_BEEF exactly 2 cycles after the read accept.
//  2. ACK_WAIT=3, req held 1 cycle then dropped -> no ack, no RAM change.
//     Req held 4+ cycles -> ack exactly in the 4th cycle of req.
//  3. Back-to-back reads of 0x0, 0x4, 0x8 (preloaded 1, 2, 3) on consecutive cycles
//     -> three consecutive resp pulses with rdata 1, 2, 3, the first 2 cycles after the first accept.
//  4. DEPTH=256: write 0x0000_0400 data 0x55 -> read 0x0 returns 0x55 (alias).
//     Read 0x0000_0013 returns the same word as 0x10.
//  5. Issue 2 reads, assert rst for 1 cycle before their resp is due -> no resp after reset;
//     ack, resp and rdata are 0 in the cycle after reset.
//  6. Write 0x20 = 0xA then read 0x20 in the next cycle -> resp returns 0xA.
//     Read 0x20, then write 0x20 = 0xB one cycle later -> the read still returns 0xA.

Source files
------------

// File: rtl/xbar_slave_mem_if.sv
// Request/response bundle between one cross-bar slave port and its endpoint.
interface xbar_slave_mem_if;
  logic        master_slave_req;
  logic [31:0] master_slave_addr;
  logic        master_slave_cmd;
  logic [31:0] master_slave_wdata;
  logic        slave_master_ack;
  logic [31:0] slave_master_rdata;
  logic        slave_master_resp;

  modport master (
    output master_slave_req, master_slave_addr, master_slave_cmd, master_slave_wdata,
    input  slave_master_ack, slave_master_rdata, slave_master_resp
  );

  modport slave (
    input  master_slave_req, master_slave_addr, master_slave_cmd, master_slave_wdata,
    output slave_master_ack, slave_master_rdata, slave_master_resp
  );
endinterface

// File: rtl/xbar_slave_mem.sv
// Word-addressed RAM endpoint for a cross-bar slave port, with programmable
// ack wait-states and a fixed-latency, fully pipelined read response path.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no request being stalled; wcnt is 0
// ST_WAIT | request held, counting wait-states until wcnt reaches ACK_WAIT
module xbar_slave_mem #(
  parameter int DEPTH      = 256,
  parameter int ACK_WAIT   = 0,
  parameter int RD_LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  xbar_slave_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] ACK_W = 4'(ACK_WAIT);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic                  ack;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [AW-1:0]         idx;
  logic [31:0]           mem [DEPTH];
  logic [RD_LATENCY-1:0] vld_q;
  logic [31:0]           dat_q [RD_LATENCY];
  logic                  unused_addr_bits;

  // Byte offset and the high bits are don't-care: the RAM aliases every 4*DEPTH bytes.
  assign idx              = bus.master_slave_addr[AW+1:2];
  assign unused_addr_bits = ^{bus.master_slave_addr[31:AW+2], bus.master_slave_addr[1:0]};

  // Ack is held off during reset so a request cannot slip a write in.
  assign ack    = ~rst & bus.master_slave_req & (wcnt_q == ACK_W);
  assign wr_acc = ack & bus.master_slave_cmd;
  assign rd_acc = ack & ~bus.master_slave_cmd;

  assign bus.slave_master_ack   = ack;
  assign bus.slave_master_resp  = vld_q[RD_LATENCY-1];
  assign bus.slave_master_rdata = dat_q[RD_LATENCY-1];

  // Wait-state FSM: state and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Wait-state FSM: next state; a dropped request abandons the wait without any access.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        wcnt_d = '0;
        if (bus.master_slave_req && (ACK_WAIT != 0)) begin
          state_d = ST_WAIT;
          wcnt_d  = 4'd1;
        end
      end
      ST_WAIT: begin
        if (!bus.master_slave_req || (wcnt_q == ACK_W)) begin
          state_d = ST_IDLE;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
    endcase
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[idx] <= bus.master_slave_wdata;
    end
  end

  // Read pipeline: each stage keeps its data across bubbles, so the last stage
  // holds the most recently returned word between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_acc;
      if (rd_acc) begin
        dat_q[0] <= mem[idx];
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_xbar_slave_mem.sv
// Bench for xbar_slave_mem: two instances (default parameters, and a small
// slow one with wait-states and long latency) checked every cycle against a
// transaction-level model, plus literal expectations for the key scenarios.
module tb_xbar_slave_mem;
  localparam int D0 = 256, W0 = 0, L0 = 2;
  localparam int D1 = 16,  W1 = 3, L1 = 6;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  xbar_slave_mem_if if0 ();
  xbar_slave_mem_if if1 ();

  logic        req_v   [2];
  logic        cmd_v   [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic        ack_w   [2];
  logic        resp_w  [2];
  logic [31:0] rdata_w [2];

  assign if0.master_slave_req   = req_v[0];
  assign if0.master_slave_cmd   = cmd_v[0];
  assign if0.master_slave_addr  = addr_v[0];
  assign if0.master_slave_wdata = wdata_v[0];
  assign if1.master_slave_req   = req_v[1];
  assign if1.master_slave_cmd   = cmd_v[1];
  assign if1.master_slave_addr  = addr_v[1];
  assign if1.master_slave_wdata = wdata_v[1];
  assign ack_w[0]   = if0.slave_master_ack;
  assign resp_w[0]  = if0.slave_master_resp;
  assign rdata_w[0] = if0.slave_master_rdata;
  assign ack_w[1]   = if1.slave_master_ack;
  assign resp_w[1]  = if1.slave_master_resp;
  assign rdata_w[1] = if1.slave_master_rdata;

  xbar_slave_mem #(.DEPTH(D0), .ACK_WAIT(W0), .RD_LATENCY(L0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  xbar_slave_mem #(.DEPTH(D1), .ACK_WAIT(W1), .RD_LATENCY(L1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  int          checks = 0;
  int          fails  = 0;
  bit          chk_en = 1'b0;
  int unsigned cyc    = 0;

  // model state
  int          hold     [2];
  logic [31:0] last     [2];
  logic        exp_resp [2];
  logic [31:0] mm       [2][256];
  logic        sv       [2][16];
  logic [31:0] sd       [2][16];

  // response log
  int          rlog_c [2][1024];
  logic [31:0] rlog_d [2][1024];
  int          rcnt   [2];

  function automatic int ackw(input int n);
    return (n == 0) ? W0 : W1;
  endfunction

  function automatic int lat(input int n);
    return (n == 0) ? L0 : L1;
  endfunction

  function automatic int midx(input int n, input logic [31:0] a);
    int dep;
    dep = (n == 0) ? D0 : D1;
    return int'({2'b00, a[31:2]}) % dep;
  endfunction

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] cyc=%0d got=%h want=%h", nm, n, cyc, act, exp);
    end
  endtask

  // Model: a request is accepted once it has been held ACK_WAIT prior cycles;
  // reads are scheduled on a calendar RD_LATENCY cycles after acceptance.
  initial begin
    for (int n = 0; n < 2; n++) begin
      hold[n] = 0; last[n] = '0; exp_resp[n] = 1'b0; rcnt[n] = 0;
      for (int k = 0; k < 16; k++) sv[n][k] = 1'b0;
    end
    forever begin
      @(posedge clk);
      for (int n = 0; n < 2; n++) begin
        if (rst) begin
          hold[n] = 0;
          last[n] = '0;
          for (int k = 0; k < 16; k++) sv[n][k] = 1'b0;
        end else if (req_v[n] !== 1'b1) begin
          hold[n] = 0;
        end else if (hold[n] == ackw(n)) begin
          if (cmd_v[n]) begin
            mm[n][midx(n, addr_v[n])] = wdata_v[n];
          end else begin
            sv[n][(cyc + lat(n)) % 16] = 1'b1;
            sd[n][(cyc + lat(n)) % 16] = mm[n][midx(n, addr_v[n])];
          end
          hold[n] = 0;
        end else begin
          hold[n]++;
        end
      end
      cyc++;
      for (int n = 0; n < 2; n++) begin
        exp_resp[n] = sv[n][cyc % 16];
        if (exp_resp[n]) begin
          last[n] = sd[n][cyc % 16];
          sv[n][cyc % 16] = 1'b0;
        end
      end
    end
  end

  // Compare process, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (chk_en) begin
          chk("ack", n, {31'b0, ack_w[n]},
              {31'b0, (rst !== 1'b1) && (req_v[n] === 1'b1) && (hold[n] == ackw(n))});
          chk("resp", n, {31'b0, resp_w[n]}, {31'b0, exp_resp[n]});
          chk("rdata", n, rdata_w[n], last[n]);
        end
        if (resp_w[n] === 1'b1 && rcnt[n] < 1024) begin
          rlog_c[n][rcnt[n]] = int'(cyc);
          rlog_d[n][rcnt[n]] = rdata_w[n];
          rcnt[n]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) tick();
  endtask

  task automatic issue(input int n, input logic c, input logic [31:0] a, input logic [31:0] d,
                       output int waited, output int acc);
    req_v[n] = 1'b1; cmd_v[n] = c; addr_v[n] = a; wdata_v[n] = d;
    waited = -1; acc = -1;
    for (int i = 0; i < 32 && waited < 0; i++) begin
      @(negedge clk);
      if (ack_w[n] === 1'b1) begin
        waited = i;
        acc    = int'(cyc);
      end
      tick();
    end
    req_v[n] = 1'b0;
    checks++;
    if (waited < 0) begin
      fails++;
      $display("FAIL ack_timeout[%0d] cyc=%0d got=no_ack want=ack", n, cyc);
    end
  endtask

  task automatic rd_check(input int n, input logic [31:0] a, input logic [31:0] e, input string nm);
    int r0, w, ac;
    r0 = rcnt[n];
    issue(n, 1'b0, a, 32'h0, w, ac);
    idle(lat(n) + 1);
    chk({nm, "_cnt"}, n, 32'(rcnt[n] - r0), 32'd1);
    if (rcnt[n] > r0) begin
      chk({nm, "_lat"}, n, 32'(rlog_c[n][r0] - ac), 32'(lat(n)));
      chk({nm, "_data"}, n, rlog_d[n][r0], e);
    end
  endtask

  initial begin
    int w, a0, a1, r0;
    rst = 1'b1;
    for (int n = 0; n < 2; n++) begin
      req_v[n] = 1'b0; cmd_v[n] = 1'b0; addr_v[n] = '0; wdata_v[n] = '0;
    end
    idle(3);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      chk("rst_ack", n, {31'b0, ack_w[n]}, 32'd0);
      chk("rst_resp", n, {31'b0, resp_w[n]}, 32'd0);
      chk("rst_rdata", n, rdata_w[n], 32'd0);
    end
    tick();

    // preload both RAMs
    for (int i = 0; i < D0; i++) issue(0, 1'b1, 32'(i * 4), $urandom, w, a0);
    for (int i = 0; i < D1; i++) issue(1, 1'b1, 32'(i * 4), 32'h1000 + 32'(i), w, a0);

    // basic write then read
    issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, w, a0);
    chk("t1_wr_wait", 0, 32'(w), 32'd0);
    rd_check(0, 32'h10, 32'hDEAD_BEEF, "t1_rd");

    // back-to-back reads
    issue(0, 1'b1, 32'h0, 32'd1, w, a0);
    issue(0, 1'b1, 32'h4, 32'd2, w, a0);
    issue(0, 1'b1, 32'h8, 32'd3, w, a0);
    r0 = rcnt[0];
    issue(0, 1'b0, 32'h0, 32'h0, w, a0);
    issue(0, 1'b0, 32'h4, 32'h0, w, a1);
    issue(0, 1'b0, 32'h8, 32'h0, w, a1);
    idle(5);
    chk("t3_cnt", 0, 32'(rcnt[0] - r0), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk("t3_cyc", 0, 32'(rlog_c[0][r0 + k] - a0), 32'(2 + k));
      chk("t3_data", 0, rlog_d[0][r0 + k], 32'(k + 1));
    end

    // aliasing and ignored byte offset
    issue(0, 1'b1, 32'h0000_0400, 32'h55, w, a0);
    rd_check(0, 32'h0, 32'h55, "t4_alias");
    rd_check(0, 32'h13, 32'hDEAD_BEEF, "t4_byteoff");

    // read-after-write and write-after-read ordering
    issue(0, 1'b1, 32'h20, 32'hA, w, a0);
    rd_check(0, 32'h20, 32'hA, "t6_raw");
    r0 = rcnt[0];
    issue(0, 1'b0, 32'h20, 32'h0, w, a0);
    issue(0, 1'b1, 32'h20, 32'hB, w, a1);
    idle(4);
    chk("t6_war_cnt", 0, 32'(rcnt[0] - r0), 32'd1);
    chk("t6_war_data", 0, rlog_d[0][r0], 32'hA);
    rd_check(0, 32'h20, 32'hB, "t6_new");

    // wait-states: abandoned request, then a held one
    req_v[1] = 1'b1; cmd_v[1] = 1'b1; addr_v[1] = 32'h8; wdata_v[1] = 32'hBAD;
    @(negedge clk);
    chk("t2_abandon_ack", 1, {31'b0, ack_w[1]}, 32'd0);
    tick();
    req_v[1] = 1'b0;
    idle(2);
    rd_check(1, 32'h8, 32'h1002, "t2_noWrite");
    issue(1, 1'b1, 32'h8, 32'h77, w, a0);
    chk("t2_wait", 1, 32'(w), 32'd3);
    rd_check(1, 32'h48, 32'h77, "t2_alias");
    rd_check(1, 32'hFFFF_FFCB, 32'h77, "t2_hialias");

    // reset with two reads in flight
    r0 = rcnt[1];
    issue(1, 1'b0, 32'h0, 32'h0, w, a0);
    issue(1, 1'b0, 32'h4, 32'h0, w, a1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      chk("t5_ack", n, {31'b0, ack_w[n]}, 32'd0);
      chk("t5_resp", n, {31'b0, resp_w[n]}, 32'd0);
      chk("t5_rdata", n, rdata_w[n], 32'd0);
    end
    tick();
    idle(12);
    chk("t5_noresp", 1, 32'(rcnt[1] - r0), 32'd0);

    // randomized traffic, model-checked every cycle
    for (int n = 0; n < 2; n++) begin
      for (int t = 0; t < 250; t++) begin
        if (n == 1 && $urandom_range(0, 5) == 0) begin
          req_v[1] = 1'b1; cmd_v[1] = 1'($urandom_range(0, 1));
          addr_v[1] = $urandom; wdata_v[1] = $urandom;
          idle($urandom_range(1, 3));
          req_v[1] = 1'b0;
        end else begin
          issue(n, 1'($urandom_range(0, 1)), $urandom, $urandom, w, a0);
        end
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
      idle(lat(n) + 2);
    end

    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
